// File: rtl/cu_fsm.sv
// OTTER multicycle control unit: INIT/FETCH/EXEC/WRITEBACK/INTERRUPT sequencer; outputs are combinational from state and opcode.
// Latency: 2 cycles per instruction, 3 for loads, plus 1 for interrupt entry; no backpressure, the sequencer never stalls.
module cu_fsm #(
    parameter bit INTR_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    output logic       PC_WRITE,
    output logic       PC_RST,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    state_t state;
    state_t state_nxt;
    logic   take_intr;
    state_t boundary_nxt;

    // Interrupts are only honoured where an instruction retires.
    assign take_intr    = INTR_EN && INTR;
    assign boundary_nxt = take_intr ? ST_INTR : ST_FETCH;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_INIT;
        PC_WRITE  = 1'b0;
        PC_RST    = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;

        case (state)
            ST_INIT: begin
                PC_RST    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (OPCODE == OP_LOAD) begin
                    // PC holds until writeback so the load retires before any interrupt entry.
                    MEM_RDEN2 = 1'b1;
                    state_nxt = ST_WB;
                end else begin
                    PC_WRITE  = 1'b1;
                    state_nxt = boundary_nxt;
                    case (OPCODE)
                        OP_STORE: MEM_WE2 = 1'b1;
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: REG_WRITE = 1'b1;
                        OP_SYSTEM: begin
                            if (FUNC3 == F3_CSRRW) begin
                                CSR_WE    = 1'b1;
                                REG_WRITE = 1'b1;
                            end else if (FUNC3 == F3_MRET) begin
                                MRET_EXEC = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WB: begin
                REG_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
                state_nxt = boundary_nxt;
            end
            ST_INTR: begin
                // MIE is cleared upstream on entry, so return to fetch unconditionally.
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign STATE = state;

endmodule
